hazard_ctrl: RTL

Pipeline hazard controller for the five-stage core. It sequences the IF/ID pipeline register, the PC register and the ID/EX control bubble. It generates the load strobe, flush and bubble signals for load-use stalls, taken-branch flushes and data-memory wait freezes. It sits beside the ID stage and takes hazard inputs from ID, EX and the data-memory interface.

---
 rtl/hazard_ctrl_if.sv | 14 +
 rtl/hazard_ctrl.sv | 70 +++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from ID/EX/dmem and the pipeline control strobes.
interface hazard_ctrl_if #(parameter int REG_ADDR_W = 5);
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, mem_busy;
  logic pc_write, enable_if, flush_if, bubble_ex;
  modport master (
    output id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, mem_busy,
    input  pc_write, enable_if, flush_if, bubble_ex
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, mem_busy,
    output pc_write, enable_if, flush_if, bubble_ex
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and memory freeze sequencing for the 5-stage core.
// HAZARD_CTRL_PERF_EN adds the stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  hazard_ctrl_if.slave h,
  output logic [1:0] state
`ifdef HAZARD_CTRL_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, FREEZE = 2'd2} st_t;
  st_t st;
  logic [1:0] fcnt;
  logic br_pend, ret_flush;
  logic lu, br, ret, fl, stall;
  assign state = st;
  always_comb begin
    lu = h.ex_memread && h.ex_rd != REG_ADDR_W'(0) &&
         ((h.id_uses_rs1 && h.id_rs1 == h.ex_rd) || (h.id_uses_rs2 && h.id_rs2 == h.ex_rd));
    br = st != FLUSH && (h.ex_branch_taken || br_pend);
    // release of a freeze that interrupted a flush resumes the remaining flush cycles
    ret = st == FREEZE && ret_flush && fcnt != 2'd0;
    fl = !h.mem_busy && (br || st == FLUSH);
    stall = !h.mem_busy && !fl && !ret && lu;
    h.flush_if = rst || fl;
    h.bubble_ex = rst || fl || stall;
    h.pc_write = !rst && !h.mem_busy && !stall;
    h.enable_if = !rst && !h.mem_busy && !stall;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= RUN;
      fcnt <= 2'd0;
      br_pend <= 1'b0;
      ret_flush <= 1'b0;
    end else if (h.mem_busy) begin
      st <= FREEZE;
      if (h.ex_branch_taken) br_pend <= 1'b1;
      if (st != FREEZE) ret_flush <= st == FLUSH;
    end else if (br) begin
      br_pend <= 1'b0;
      fcnt <= 2'(FLUSH_CYCLES - 1);
      st <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
    end else if (st == FLUSH) begin
      fcnt <= fcnt - 2'd1;
      st <= fcnt == 2'd1 ? RUN : FLUSH;
    end else begin
      st <= ret ? FLUSH : RUN;
    end
  end
`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(!h.pc_write);
      flush_cnt <= flush_cnt + CNT_W'(h.flush_if);
    end
  end
`endif
endmodule
